step_watchdog: RTL and testbench

N-channel stepper activity watchdog. Each channel's idle time is measured in clk cycles since its last step edge, and a stale channel is flagged. When armed, an idle-expired channel in the shutdown mask latches a shutdown request into the command block.
Generalises the fixed 6-channel, fixed 10 s, single-channel-shutdown step watcher with:
- per-channel programmable timeouts
- a shutdown mask
- arm polarity
- a clear input
- first-cause reporting
- a debug readout

---
 rtl/step_watchdog_pkg.sv | 28 ++
 rtl/step_watchdog_if.sv | 34 +++
 rtl/step_watchdog_chan.sv | 48 ++++
 rtl/step_watchdog.sv | 115 +++++++++++
 tb/tb_step_watchdog.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/step_watchdog_pkg.sv
// Shared types, width helpers and status-word layout for the step activity watchdog.
package step_watchdog_pkg;

   localparam int unsigned DBG_BITS = 8;

   // Status word bit positions as seen by the command block.
   localparam int unsigned STAT_ALERT_LSB    = 0;
   localparam int unsigned STAT_STICKY_LSB   = 8;
   localparam int unsigned STAT_SHUTDOWN_BIT = 16;
   localparam int unsigned STAT_ARMED_BIT    = 17;
   localparam int unsigned STAT_CHAN_LSB     = 24;

   typedef enum logic [1:0] {
      WD_DISARMED = 2'd0,
      WD_ARMED    = 2'd1,
      WD_TRIPPED  = 2'd2
   } wd_state_t;

   function automatic int unsigned ch_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Ten seconds of idle time at the given clock rate.
   function automatic longint unsigned default_timeout(input longint unsigned hz);
      return hz * 64'd10;
   endfunction

endpackage

// File: rtl/step_watchdog_if.sv
// Step inputs, configuration strobes and status outputs of the step watchdog.
interface step_watchdog_if
   import step_watchdog_pkg::*;
#(
   parameter int unsigned NCHAN    = 6,
   parameter int unsigned CNT_BITS = 32,
   parameter int unsigned CH_BITS  = ch_bits(NCHAN)
);
   logic [NCHAN-1:0]    step;
   logic                arm_in;
   logic                cfg_to_wr;
   logic [CH_BITS-1:0]  cfg_addr;
   logic [CNT_BITS-1:0] cfg_timeout;
   logic                cfg_mask_wr;
   logic [NCHAN-1:0]    cfg_mask;
   logic                clr;
   logic [NCHAN-1:0]    alert;
   logic [NCHAN-1:0]    alert_sticky;
   logic                armed;
   logic                req_shutdown;
   logic [CH_BITS-1:0]  shutdown_chan;
   logic [CH_BITS-1:0]  dbg_sel;
   logic [DBG_BITS-1:0] dbg_idle;

   modport master (
      output step, arm_in, cfg_to_wr, cfg_addr, cfg_timeout, cfg_mask_wr, cfg_mask, clr, dbg_sel,
      input  alert, alert_sticky, armed, req_shutdown, shutdown_chan, dbg_idle
   );

   modport slave (
      input  step, arm_in, cfg_to_wr, cfg_addr, cfg_timeout, cfg_mask_wr, cfg_mask, clr, dbg_sel,
      output alert, alert_sticky, armed, req_shutdown, shutdown_chan, dbg_idle
   );
endinterface

// File: rtl/step_watchdog_chan.sv
// One monitored step channel: edge detect, saturating idle counter, timeout and alerts.
module step_watchdog_chan #(
   parameter int unsigned     CNT_BITS        = 32,
   parameter longint unsigned DEFAULT_TIMEOUT = 64'd480000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step,
   input  logic                clr,
   input  logic                to_wr,
   input  logic [CNT_BITS-1:0] to_val,
   output logic [CNT_BITS-1:0] count,
   output logic                exp_c,
   output logic                alert,
   output logic                alert_sticky
);

   logic                prev_step;
   logic [CNT_BITS-1:0] timeout;

   // A zero timeout disables the channel entirely.
   assign exp_c = (timeout != '0) && (count >= timeout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_step    <= 1'b0;
         count        <= '0;
         timeout      <= CNT_BITS'(DEFAULT_TIMEOUT);
         alert        <= 1'b0;
         alert_sticky <= 1'b0;
      end else begin
         prev_step <= step;
         if (step != prev_step) begin
            count <= '0;
         end else if (timeout == '0) begin
            count <= '0;
         end else if (count < timeout) begin
            count <= count + CNT_BITS'(1);
         end
         if (to_wr) begin
            timeout <= to_val;
         end
         alert        <= exp_c;
         alert_sticky <= clr ? 1'b0 : (alert_sticky | exp_c);
      end
   end

endmodule

// File: rtl/step_watchdog.sv
// N-channel step activity watchdog with armed, latched first-cause shutdown request.
module step_watchdog
   import step_watchdog_pkg::*;
#(
   parameter int unsigned     NCHAN           = 6,
   parameter int unsigned     CNT_BITS        = 32,
   parameter int unsigned     HZ              = 48000000,
   parameter longint unsigned DEFAULT_TIMEOUT = default_timeout(64'(HZ)),
   parameter logic [NCHAN-1:0] DEFAULT_MASK   = NCHAN'(6'b100000),
   parameter bit              ARM_POL         = 1'b0,
   parameter int unsigned     CH_BITS         = ch_bits(NCHAN)
) (
   input logic           clk,
   input logic           rst,
   step_watchdog_if.slave bus
);

   logic [CNT_BITS-1:0] count [NCHAN];
   logic [NCHAN-1:0]    exp_c;
   logic [NCHAN-1:0]    alert_v;
   logic [NCHAN-1:0]    sticky_v;
   logic [NCHAN-1:0]    mask_q;
   logic [NCHAN-1:0]    hit_c;
   logic [CH_BITS-1:0]  first_c;
   logic [1:0]          arm_sync_q;
   wd_state_t           state_q, state_d;
   logic [CH_BITS-1:0]  chan_q, chan_d;
   logic [DBG_BITS-1:0] dbg_c, dbg_q;

   for (genvar i = 0; i < int'(NCHAN); i++) begin : g_chan
      step_watchdog_chan #(
         .CNT_BITS       (CNT_BITS),
         .DEFAULT_TIMEOUT(DEFAULT_TIMEOUT)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .step        (bus.step[i]),
         .clr         (bus.clr),
         .to_wr       (bus.cfg_to_wr && (bus.cfg_addr == CH_BITS'(i))),
         .to_val      (bus.cfg_timeout),
         .count       (count[i]),
         .exp_c       (exp_c[i]),
         .alert       (alert_v[i]),
         .alert_sticky(sticky_v[i])
      );
   end

   // Lowest expired channel in the shutdown mask.
   always_comb begin
      hit_c   = exp_c & mask_q;
      first_c = '0;
      for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
         if (hit_c[i]) first_c = CH_BITS'(i);
      end
   end

   always_comb begin
      dbg_c = '0;
      for (int i = 0; i < int'(NCHAN); i++) begin
         if (bus.dbg_sel == CH_BITS'(i)) dbg_c = count[i][CNT_BITS-1 -: DBG_BITS];
      end
   end

   // Synchroniser resets to 0, so with active-low arming the block arms on the first clock after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_sync_q <= '0;
         mask_q     <= DEFAULT_MASK;
         dbg_q      <= '0;
      end else begin
         arm_sync_q <= {arm_sync_q[0], bus.arm_in};
         if (bus.cfg_mask_wr) mask_q <= bus.cfg_mask;
         dbg_q <= dbg_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WD_DISARMED;
         chan_q  <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
      end
   end

   // clr overrides arming and a same-cycle trip; the first trip cause is held until clr.
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      if (bus.clr) begin
         state_d = WD_DISARMED;
         chan_d  = '0;
      end else begin
         case (state_q)
            WD_DISARMED: if (arm_sync_q[1] == ARM_POL) state_d = WD_ARMED;
            WD_ARMED: begin
               if (|hit_c) begin
                  state_d = WD_TRIPPED;
                  chan_d  = first_c;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign bus.alert         = alert_v;
   assign bus.alert_sticky  = sticky_v;
   assign bus.armed         = (state_q != WD_DISARMED);
   assign bus.req_shutdown  = (state_q == WD_TRIPPED);
   assign bus.shutdown_chan = chan_q;
   assign bus.dbg_idle      = dbg_q;

endmodule

// File: tb/tb_step_watchdog.sv
// Directed self-checking bench for step_watchdog (6 channels, 12-bit counters, 4000-cycle default timeout).
module tb_step_watchdog;
   import step_watchdog_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   step_watchdog_if #(.NCHAN(6), .CNT_BITS(12)) bus ();

   step_watchdog #(.NCHAN(6), .CNT_BITS(12), .HZ(400)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the DUT just out of reset, disarmed, all counts at 2.
   task automatic reset_dut();
      rst = 1'b1;
      bus.step = '0; bus.arm_in = 1'b1; bus.cfg_to_wr = 1'b0; bus.cfg_addr = '0;
      bus.cfg_timeout = '0; bus.cfg_mask_wr = 1'b0; bus.cfg_mask = '0; bus.clr = 1'b0; bus.dbg_sel = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
      bus.clr = 1'b1;
      tick(1);
      bus.clr = 1'b0;
   endtask

   task automatic write_to(input int ch, input int val);
      bus.cfg_to_wr = 1'b1; bus.cfg_addr = 3'(ch); bus.cfg_timeout = 12'(val);
      tick(1);
      bus.cfg_to_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      write_to(0, 3);
      tick(10);
      rst = 1'b1;
      #2;
      checks++; if (bus.alert !== 6'b0) begin errors++; $display("FAIL rst_alert: got %b want 000000", bus.alert); end
      checks++; if (bus.alert_sticky !== 6'b0) begin errors++; $display("FAIL rst_sticky: got %b want 000000", bus.alert_sticky); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b want 0", bus.armed); end
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.req_shutdown); end
      checks++; if (bus.dbg_idle !== 8'd0) begin errors++; $display("FAIL rst_dbg: got %0d want 0", bus.dbg_idle); end
      tick(1);
      rst = 1'b0;
      tick(1000);
      checks++; if (bus.alert_sticky !== 6'b0) begin errors++; $display("FAIL default_timeout_sticky: got %b want 000000", bus.alert_sticky); end
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL default_timeout_req: got %b want 0", bus.req_shutdown); end
      bus.arm_in = 1'b0;
      for (int ch = 0; ch < 6; ch++) write_to(ch, 20);
      tick(5);
      checks++; if (bus.alert !== 6'b111111) begin errors++; $display("FAIL default_mask_alert: got %b want 111111", bus.alert); end
      checks++; if (bus.req_shutdown !== 1'b1) begin errors++; $display("FAIL default_mask_req: got %b want 1", bus.req_shutdown); end
      checks++; if (bus.shutdown_chan !== 3'd5) begin errors++; $display("FAIL default_mask_chan: got %0d want 5", bus.shutdown_chan); end
   endtask

   task automatic test_timeout();
      reset_dut();
      write_to(0, 5);
      bus.step[0] = 1'b1;
      tick(1);
      tick(5);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL to_early: got %b want 000000", bus.alert); end
      tick(1);
      checks++; if (bus.alert !== 6'b000001) begin errors++; $display("FAIL to_rise: got %b want 000001", bus.alert); end
      checks++; if (bus.alert_sticky !== 6'b000001) begin errors++; $display("FAIL to_sticky_set: got %b want 000001", bus.alert_sticky); end
      bus.step[0] = 1'b0;
      tick(1);
      checks++; if (bus.alert !== 6'b000001) begin errors++; $display("FAIL to_hold: got %b want 000001", bus.alert); end
      tick(1);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL to_fall: got %b want 000000", bus.alert); end
      checks++; if (bus.alert_sticky !== 6'b000001) begin errors++; $display("FAIL to_sticky_keep: got %b want 000001", bus.alert_sticky); end
   endtask

   task automatic test_shutdown();
      reset_dut();
      bus.cfg_mask_wr = 1'b1; bus.cfg_mask = 6'b000100;
      write_to(2, 10);
      bus.cfg_mask_wr = 1'b0;
      bus.arm_in = 1'b0;
      bus.step[2] = 1'b1;
      tick(2);
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL arm_early: got %b want 0", bus.armed); end
      tick(1);
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL arm_latency: got %b want 1", bus.armed); end
      tick(8);
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL sd_early: got %b want 0", bus.req_shutdown); end
      tick(1);
      checks++; if (bus.req_shutdown !== 1'b1) begin errors++; $display("FAIL sd_fire: got %b want 1", bus.req_shutdown); end
      checks++; if (bus.shutdown_chan !== 3'd2) begin errors++; $display("FAIL sd_chan: got %0d want 2", bus.shutdown_chan); end
      checks++; if (bus.alert !== 6'b000100) begin errors++; $display("FAIL sd_alert: got %b want 000100", bus.alert); end
      // Same scenario with arm_in held inactive.
      reset_dut();
      bus.cfg_mask_wr = 1'b1; bus.cfg_mask = 6'b000100;
      write_to(2, 10);
      bus.cfg_mask_wr = 1'b0;
      bus.step[2] = 1'b1;
      tick(15);
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL unarmed_req: got %b want 0", bus.req_shutdown); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL unarmed_armed: got %b want 0", bus.armed); end
      checks++; if (bus.alert !== 6'b000100) begin errors++; $display("FAIL unarmed_alert: got %b want 000100", bus.alert); end
   endtask

   task automatic test_priority();
      reset_dut();
      bus.arm_in = 1'b0;
      bus.cfg_mask_wr = 1'b1; bus.cfg_mask = 6'b010100;
      write_to(2, 8);
      bus.cfg_mask_wr = 1'b0;
      write_to(4, 8);
      bus.step = 6'b010100;
      tick(1);
      tick(8);
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL prio_early: got %b want 0", bus.req_shutdown); end
      tick(1);
      checks++; if (bus.req_shutdown !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", bus.req_shutdown); end
      checks++; if (bus.shutdown_chan !== 3'd2) begin errors++; $display("FAIL prio_chan: got %0d want 2", bus.shutdown_chan); end
      bus.step[4] = 1'b0;
      write_to(2, 0);
      tick(1);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL prio_drop: got %b want 000000", bus.alert); end
      tick(8);
      checks++; if (bus.alert !== 6'b010000) begin errors++; $display("FAIL prio_ch4_alert: got %b want 010000", bus.alert); end
      checks++; if (bus.shutdown_chan !== 3'd2) begin errors++; $display("FAIL prio_chan_held: got %0d want 2", bus.shutdown_chan); end
   endtask

   task automatic test_reprogram();
      reset_dut();
      bus.step[1] = 1'b1;
      tick(1);
      tick(100);
      write_to(1, 50);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL rp_early: got %b want 000000", bus.alert); end
      tick(1);
      checks++; if (bus.alert !== 6'b000010) begin errors++; $display("FAIL rp_expire_now: got %b want 000010", bus.alert); end
      write_to(1, 0);
      tick(1);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL rp_disable: got %b want 000000", bus.alert); end
      tick(4);
      write_to(1, 3);
      tick(3);
      checks++; if (bus.alert !== 6'b000000) begin errors++; $display("FAIL rp_count_zeroed: got %b want 000000", bus.alert); end
      tick(1);
      checks++; if (bus.alert !== 6'b000010) begin errors++; $display("FAIL rp_reenable: got %b want 000010", bus.alert); end
      write_to(7, 0);
      tick(2);
      checks++; if (bus.alert !== 6'b000010) begin errors++; $display("FAIL rp_bad_addr: got %b want 000010", bus.alert); end
   endtask

   task automatic test_clr();
      reset_dut();
      bus.cfg_mask_wr = 1'b1; bus.cfg_mask = 6'b000001;
      write_to(0, 6);
      bus.cfg_mask_wr = 1'b0;
      bus.arm_in = 1'b0;
      bus.step[0] = 1'b1;
      tick(1);
      tick(6);
      bus.clr = 1'b1;
      tick(1);
      bus.clr = 1'b0;
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL clr_req: got %b want 0", bus.req_shutdown); end
      checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL clr_armed: got %b want 0", bus.armed); end
      checks++; if (bus.alert_sticky !== 6'b000000) begin errors++; $display("FAIL clr_sticky: got %b want 000000", bus.alert_sticky); end
      checks++; if (bus.alert !== 6'b000001) begin errors++; $display("FAIL clr_alert_kept: got %b want 000001", bus.alert); end
      tick(1);
      checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL clr_rearm: got %b want 1", bus.armed); end
      checks++; if (bus.req_shutdown !== 1'b0) begin errors++; $display("FAIL clr_req_gap: got %b want 0", bus.req_shutdown); end
      checks++; if (bus.alert_sticky !== 6'b000001) begin errors++; $display("FAIL clr_sticky_reset: got %b want 000001", bus.alert_sticky); end
      tick(1);
      checks++; if (bus.req_shutdown !== 1'b1) begin errors++; $display("FAIL clr_refire: got %b want 1", bus.req_shutdown); end
      bus.dbg_sel = 3'd2;
      bus.step[2] = 1'b1;
      tick(1);
      tick(300);
      checks++; if (bus.dbg_idle !== 8'd18) begin errors++; $display("FAIL dbg_ch2: got %0d want 18", bus.dbg_idle); end
      bus.dbg_sel = 3'd7;
      tick(1);
      checks++; if (bus.dbg_idle !== 8'd0) begin errors++; $display("FAIL dbg_bad_sel: got %0d want 0", bus.dbg_idle); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_timeout();
      test_shutdown();
      test_priority();
      test_reprogram();
      test_clr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
